// File: rtl/latency_window_checker.sv
// rtl/latency_window_checker.sv - in-order latency window scoreboard, pass/fail counters when LVCHK_STATS_EN is defined
module latency_window_checker #(
    parameter int WIDTH   = 8,
    parameter int MIN_LAT = 1,
    parameter int MAX_LAT = 5,
    parameter int DEPTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_en,
    input  logic [WIDTH-1:0]       portin,
    input  logic                   out_en,
    input  logic [WIDTH-1:0]       portout,
    output logic                   pass,
    output logic                   fail,
    output logic [1:0]             fail_code,
    output logic [$clog2(DEPTH):0] outstanding,
    output logic [15:0]            pass_cnt,
    output logic [15:0]            fail_cnt
);

    localparam int SW = $clog2(MAX_LAT + 1) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [SW-1:0] MIN_AGE   = SW'(MIN_LAT);
    localparam logic [SW-1:0] MAX_AGE   = SW'(MAX_LAT);
    localparam logic [CW-1:0] FULL_OCC  = CW'(DEPTH);

    localparam logic [1:0] CODE_MISMATCH = 2'd0;
    localparam logic [1:0] CODE_TIMEOUT  = 2'd1;
    localparam logic [1:0] CODE_UNEXP    = 2'd2;
    localparam logic [1:0] CODE_OVERFLOW = 2'd3;

    logic [WIDTH-1:0] q_data  [DEPTH];
    logic [SW-1:0]    q_stamp [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [SW-1:0]    now;

    logic             empty;
    logic [SW-1:0]    age;
    logic             head_pass;
    logic             head_fail;
    logic [1:0]       head_code;
    logic             pop;
    logic             push;
    logic             ovf;
    logic [CW-1:0]    occ_after_pop;

    // Head decision first, then push against the occupancy left after any pop
    always_comb begin
        empty         = (outstanding == '0);
        age           = now - q_stamp[rd_ptr];
        head_pass     = 1'b0;
        head_fail     = 1'b0;
        head_code     = CODE_MISMATCH;
        pop           = 1'b0;
        if (out_en) begin
            if (empty) begin
                head_fail = 1'b1;
                head_code = CODE_UNEXP;
            end else if (age < MIN_AGE) begin
                head_fail = 1'b1;
                head_code = CODE_UNEXP;
                pop       = 1'b1;
            end else if (portout == q_data[rd_ptr]) begin
                head_pass = 1'b1;
                pop       = 1'b1;
            end else begin
                head_fail = 1'b1;
                head_code = CODE_MISMATCH;
                pop       = 1'b1;
            end
        end else if (!empty && (age == MAX_AGE)) begin
            head_fail = 1'b1;
            head_code = CODE_TIMEOUT;
            pop       = 1'b1;
        end
        occ_after_pop = outstanding - {{AW{1'b0}}, pop};
        ovf           = in_en && (occ_after_pop == FULL_OCC);
        push          = in_en && !ovf;
    end

    // Queue storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wr_ptr]  <= portin;
            q_stamp[wr_ptr] <= now;
        end
    end

    // Stamp counter, queue pointers, occupancy and registered result pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now         <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            outstanding <= '0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            fail_code   <= 2'd0;
        end else begin
            now         <= now + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            outstanding <= outstanding - {{AW{1'b0}}, pop} + {{AW{1'b0}}, push};
            pass        <= head_pass;
            fail        <= head_fail | ovf;
            fail_code   <= ovf ? CODE_OVERFLOW : (head_fail ? head_code : 2'd0);
        end
    end

`ifdef LVCHK_STATS_EN
    logic [16:0] fail_sum;

    assign fail_sum = {1'b0, fail_cnt} + {16'd0, head_fail} + {16'd0, ovf};

    // Saturating statistics; a head fail plus an overflow in one cycle counts twice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt <= 16'h0;
            fail_cnt <= 16'h0;
        end else begin
            if (head_pass && (pass_cnt != 16'hFFFF)) begin
                pass_cnt <= pass_cnt + 16'd1;
            end
            fail_cnt <= fail_sum[16] ? 16'hFFFF : fail_sum[15:0];
        end
    end
`else
    assign pass_cnt = 16'h0;
    assign fail_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_latency_window_checker.sv
// tb/tb_latency_window_checker.sv - randomized and directed bench for latency_window_checker against a queue model
module tb_latency_window_checker;

    localparam int WIDTH   = 8;
    localparam int MIN_LAT = 1;
    localparam int MAX_LAT = 5;
    // Depth 4 lets the queue fill before the oldest entry reaches its timeout age
    localparam int DEPTH   = 4;

`ifdef LVCHK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                   clk;
    logic                   rst_n;
    logic                   in_en;
    logic [WIDTH-1:0]       portin;
    logic                   out_en;
    logic [WIDTH-1:0]       portout;
    logic                   pass;
    logic                   fail;
    logic [1:0]             fail_code;
    logic [$clog2(DEPTH):0] outstanding;
    logic [15:0]            pass_cnt;
    logic [15:0]            fail_cnt;

    latency_window_checker #(
        .WIDTH  (WIDTH),
        .MIN_LAT(MIN_LAT),
        .MAX_LAT(MAX_LAT),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_en      (in_en),
        .portin     (portin),
        .out_en     (out_en),
        .portout    (portout),
        .pass       (pass),
        .fail       (fail),
        .fail_code  (fail_code),
        .outstanding(outstanding),
        .pass_cnt   (pass_cnt),
        .fail_cnt   (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        int               t;
    } ent_t;

    ent_t mq[$];
    int   cyc;
    int   m_pc;
    int   m_fc;
    bit   e_pass;
    bit   e_fail;
    int   e_code;

    int   n_chk;
    int   n_err;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural reference: transactions kept with absolute push cycle numbers
    task automatic model_edge(input logic ie, input logic [WIDTH-1:0] pi,
                              input logic oe, input logic [WIDTH-1:0] po);
        bit   hf;
        bit   ov;
        int   hc;
        ent_t e;
        hf     = 1'b0;
        ov     = 1'b0;
        hc     = 0;
        e_pass = 1'b0;
        cyc++;
        if (oe) begin
            if (mq.size() == 0) begin
                hf = 1'b1;
                hc = 2;
            end else begin
                if ((cyc - mq[0].t) < MIN_LAT) begin
                    hf = 1'b1;
                    hc = 2;
                end else if (po == mq[0].d) begin
                    e_pass = 1'b1;
                end else begin
                    hf = 1'b1;
                    hc = 0;
                end
                mq.delete(0);
            end
        end else if (mq.size() != 0 && (cyc - mq[0].t) >= MAX_LAT) begin
            hf = 1'b1;
            hc = 1;
            mq.delete(0);
        end
        if (ie) begin
            if (mq.size() >= DEPTH) begin
                ov = 1'b1;
            end else begin
                e.d = pi;
                e.t = cyc;
                mq.push_back(e);
            end
        end
        e_fail = hf || ov;
        e_code = ov ? 3 : (hf ? hc : 0);
        if (e_pass && m_pc < 65535) m_pc++;
        m_fc = m_fc + int'(hf) + int'(ov);
        if (m_fc > 65535) m_fc = 65535;
    endtask

    task automatic compare_all();
        check("pass", int'(pass), int'(e_pass));
        check("fail", int'(fail), int'(e_fail));
        check("fail_code", int'(fail_code), e_code);
        check("outstanding", int'(outstanding), mq.size());
        check("pass_cnt", int'(pass_cnt), STATS ? m_pc : 0);
        check("fail_cnt", int'(fail_cnt), STATS ? m_fc : 0);
        check("pass_fail_excl", int'(pass & fail), 0);
    endtask

    task automatic step(input logic ie, input logic [WIDTH-1:0] pi,
                        input logic oe, input logic [WIDTH-1:0] po);
        in_en   = ie;
        portin  = pi;
        out_en  = oe;
        portout = po;
        @(posedge clk);
        model_edge(ie, pi, oe, po);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0);
    endtask

    task automatic do_reset();
        in_en   = 1'b0;
        out_en  = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("rst_pass", int'(pass), 0);
        check("rst_fail", int'(fail), 0);
        check("rst_code", int'(fail_code), 0);
        check("rst_outstanding", int'(outstanding), 0);
        check("rst_pass_cnt", int'(pass_cnt), 0);
        check("rst_fail_cnt", int'(fail_cnt), 0);
        mq.delete();
        m_pc = 0;
        m_fc = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        logic             ie;
        logic             oe;
        n_chk   = 0;
        n_err   = 0;
        cyc     = 0;
        m_pc    = 0;
        m_fc    = 0;
        rst_n   = 1'b0;
        in_en   = 1'b0;
        out_en  = 1'b0;
        portin  = '0;
        portout = '0;
        @(negedge clk);
        do_reset();

        // Matching response two cycles after the push
        step(1'b1, 8'h03, 1'b0, '0);
        step(1'b0, '0, 1'b0, '0);
        step(1'b0, '0, 1'b1, 8'h03);
        check("t1_pass", int'(pass), 1);
        check("t1_outstanding", int'(outstanding), 0);
        check("t1_pass_cnt", int'(pass_cnt), STATS ? 1 : 0);

        // Data mismatch at minimum latency
        step(1'b1, 8'h05, 1'b0, '0);
        step(1'b0, '0, 1'b1, 8'h06);
        check("t2_fail", int'(fail), 1);
        check("t2_code", int'(fail_code), 0);
        check("t2_fail_cnt", int'(fail_cnt), STATS ? 1 : 0);

        // Timeout exactly MAX_LAT edges after the push
        step(1'b1, 8'h02, 1'b0, '0);
        idle(MAX_LAT - 1);
        check("t3_no_early_timeout", int'(fail), 0);
        idle(1);
        check("t3_fail", int'(fail), 1);
        check("t3_code", int'(fail_code), 1);
        check("t3_outstanding", int'(outstanding), 0);

        // Response with nothing outstanding
        step(1'b0, '0, 1'b1, 8'h00);
        check("t4_fail", int'(fail), 1);
        check("t4_code", int'(fail_code), 2);
        check("t4_outstanding", int'(outstanding), 0);

        // Overflow on push DEPTH+1, then the oldest entry times out
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, '0);
        check("t5_fail", int'(fail), 1);
        check("t5_code", int'(fail_code), 3);
        check("t5_outstanding", int'(outstanding), DEPTH);
        idle(1);
        check("t5_timeout", int'(fail), 1);
        check("t5_timeout_code", int'(fail_code), 1);
        idle(DEPTH);
        check("t5_drained", int'(outstanding), 0);

        // Reset with entries pending: flushed silently, then normal operation
        step(1'b1, 8'h21, 1'b0, '0);
        step(1'b1, 8'h22, 1'b0, '0);
        step(1'b1, 8'h23, 1'b0, '0);
        do_reset();
        idle(MAX_LAT + 3);
        check("t6_no_stale_timeout", int'(fail_cnt), 0);
        step(1'b1, 8'h07, 1'b0, '0);
        idle(MAX_LAT - 1);
        step(1'b0, '0, 1'b1, 8'h07);
        check("t6_pass", int'(pass), 1);

        // Randomized traffic: mostly correct responses at random latencies
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                ie = ($urandom_range(0, 99) < 45);
                oe = ($urandom_range(0, 99) < 35);
                d  = 8'($urandom);
                if (mq.size() != 0 && $urandom_range(0, 3) != 0) d = mq[0].d;
                step(ie, 8'($urandom), oe, d);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
